// File: rtl/fifo_async_operator.sv
// Pull-handshake operand collector feeding a shared multi-reader result buffer.
// Each operand channel captures one value. Once all channels hold a value and a slot
// is free, the operands are combined by OP into a result that is appended to the buffer.
// Every consumer drains the buffer through its own read pointer.
module fifo_async_operator #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter string       OP          = "add",
  parameter int          IMMEDIATE   = 0,
  parameter int unsigned INPUT_SIZE  = 2,
  parameter int unsigned OUTPUT_SIZE = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [$clog2(DEPTH):0]            occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra wrap bit separates a full buffer from an empty one.
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] Imm = DATA_WIDTH'(IMMEDIATE);

  localparam bit IsAdd  = (OP == "add");
  localparam bit IsSub  = (OP == "sub");
  localparam bit IsMul  = (OP == "mul");
  localparam bit IsAnd  = (OP == "and");
  localparam bit IsOr   = (OP == "or");
  localparam bit IsXor  = (OP == "xor");
  localparam bit IsAddi = (OP == "addi");
  localparam bit IsSubi = (OP == "subi");
  localparam bit IsMuli = (OP == "muli");

  logic [INPUT_SIZE-1:0]                  has_q, has_d;
  logic [INPUT_SIZE-1:0]                  req_l_q, req_l_d;
  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  opnd_q, opnd_d;
  logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [OUTPUT_SIZE-1:0][PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OUTPUT_SIZE-1:0]                 ack_r_q, ack_r_d;
  logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] dout_q, dout_d;
  logic [PW-1:0]                          occ_q, occ_d;
  logic [PW-1:0]                          diff;
  logic [DATA_WIDTH-1:0]                  result;
  logic                                   fire;
  logic [DATA_WIDTH-1:0]                  mem_q [DEPTH];

  // Left fold of the captured operands under the selected operator.
  always_comb begin
    result = opnd_q[0];
    for (int unsigned i = 1; i < INPUT_SIZE; i++) begin
      if (IsAdd)      result = result + opnd_q[i];
      else if (IsSub) result = result - opnd_q[i];
      else if (IsMul) result = result * opnd_q[i];
      else if (IsAnd) result = result & opnd_q[i];
      else if (IsOr)  result = result | opnd_q[i];
      else if (IsXor) result = result ^ opnd_q[i];
    end
    if (IsAddi)      result = opnd_q[0] + Imm;
    else if (IsSubi) result = opnd_q[0] - Imm;
    else if (IsMuli) result = opnd_q[0] * Imm;
  end

  // Operand capture, fire decision, per-consumer reads and occupancy tracking.
  always_comb begin
    // Uses the registered occupancy, so a slot freed this edge is only reusable next edge.
    fire   = (&has_q) && (occ_q < DepthP);
    has_d  = has_q;
    opnd_d = opnd_q;
    for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
      if (ack_l[i] && !has_q[i]) begin
        has_d[i]  = 1'b1;
        opnd_d[i] = din[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
    if (fire) has_d = '0;
    req_l_d  = ~has_d;
    wr_ptr_d = fire ? wr_ptr_q + PtrOne : wr_ptr_q;

    rd_ptr_d = rd_ptr_q;
    ack_r_d  = '0;
    dout_d   = dout_q;
    for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
      if (req_r[j] && !ack_r_q[j] && (rd_ptr_q[j] != wr_ptr_q)) begin
        ack_r_d[j]  = 1'b1;
        dout_d[j]   = mem_q[rd_ptr_q[j][AW-1:0]];
        rd_ptr_d[j] = rd_ptr_q[j] + PtrOne;
      end
    end

    // The slowest consumer determines how many entries are still pinned.
    occ_d = '0;
    diff  = '0;
    for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
      diff = wr_ptr_d - rd_ptr_d[j];
      if (diff > occ_d) occ_d = diff;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_q    <= '0;
      req_l_q  <= '0;
      opnd_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_r_q  <= '0;
      dout_q   <= '0;
      occ_q    <= '0;
    end else begin
      has_q    <= has_d;
      req_l_q  <= req_l_d;
      opnd_q   <= opnd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      occ_q    <= occ_d;
    end
  end

  // Result storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (fire) mem_q[wr_ptr_q[AW-1:0]] <= result;
  end

  assign req_l     = req_l_q;
  assign ack_r     = ack_r_q;
  assign dout      = dout_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_fifo_async_operator.sv
// Directed bench for fifo_async_operator: add/sub/mul folds, full-buffer backpressure,
// independent consumers, asynchronous reset and a long addi stream.
module tb_fifo_async_operator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // add, 2 operands, 2 consumers, depth 4
  logic [1:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
  logic [63:0] a_din, a_dout;
  logic [2:0]  a_occ;
  fifo_async_operator #(.DATA_WIDTH(32), .OP("add"), .IMMEDIATE(0), .INPUT_SIZE(2),
                        .OUTPUT_SIZE(2), .DEPTH(4)) u_add (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .occupancy(a_occ)
  );

  // sub, 3 operands, 1 consumer
  logic [2:0]  s_req_l, s_ack_l;
  logic [0:0]  s_req_r, s_ack_r;
  logic [95:0] s_din;
  logic [31:0] s_dout;
  logic [2:0]  s_occ;
  fifo_async_operator #(.DATA_WIDTH(32), .OP("sub"), .IMMEDIATE(0), .INPUT_SIZE(3),
                        .OUTPUT_SIZE(1), .DEPTH(4)) u_sub (
    .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
    .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout), .occupancy(s_occ)
  );

  // mul, 8-bit, 2 operands, 1 consumer
  logic [1:0]  m_req_l, m_ack_l;
  logic [0:0]  m_req_r, m_ack_r;
  logic [15:0] m_din;
  logic [7:0]  m_dout;
  logic [2:0]  m_occ;
  fifo_async_operator #(.DATA_WIDTH(8), .OP("mul"), .IMMEDIATE(0), .INPUT_SIZE(2),
                        .OUTPUT_SIZE(1), .DEPTH(4)) u_mul (
    .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
    .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout), .occupancy(m_occ)
  );

  // addi +2, 1 operand, 2 consumers
  logic [0:0]  x_req_l, x_ack_l;
  logic [1:0]  x_req_r, x_ack_r;
  logic [31:0] x_din;
  logic [63:0] x_dout;
  logic [2:0]  x_occ;
  fifo_async_operator #(.DATA_WIDTH(32), .OP("addi"), .IMMEDIATE(2), .INPUT_SIZE(1),
                        .OUTPUT_SIZE(2), .DEPTH(4)) u_addi (
    .clk(clk), .rst(rst), .req_l(x_req_l), .ack_l(x_ack_l), .din(x_din),
    .req_r(x_req_r), .ack_r(x_ack_r), .dout(x_dout), .occupancy(x_occ)
  );

  // Record every result handed to each add-instance consumer.
  logic [31:0] a_got0 [$];
  logic [31:0] a_got1 [$];
  always @(negedge clk) begin
    if (a_ack_r[0]) a_got0.push_back(a_dout[31:0]);
    if (a_ack_r[1]) a_got1.push_back(a_dout[63:32]);
  end

  task automatic wait_ready_a();
    int n = 0;
    while (a_req_l != 2'b11 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("a_req_l_ready", a_req_l, 2'b11);
  endtask

  task automatic grant_a(input logic [31:0] op0, input logic [31:0] op1);
    a_din   = {op1, op0};
    a_ack_l = 2'b11;
    @(posedge clk); #1;
    a_ack_l = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exhausted, required completion");
    $fatal(1, "watchdog");
  end

  logic [7:0]  m_a [3];
  logic [7:0]  m_b [3];
  logic [7:0]  m_e [3];
  logic [31:0] x_exp [1000];
  int x_sent, x_idx0, x_idx1;

  initial begin
    a_ack_l = '0; a_din = '0; a_req_r = '0;
    s_ack_l = '0; s_din = '0; s_req_r = '0;
    m_ack_l = '0; m_din = '0; m_req_r = '0;
    x_ack_l = '0; x_din = '0; x_req_r = '0;
    m_a = '{8'd16, 8'd17, 8'd5};
    m_b = '{8'd16, 8'd15, 8'd3};
    m_e = '{8'd0, 8'd255, 8'd15};

    // Reset state
    #1 rst = 1'b0;
    #11;
    check_eq("rst_a_req_l", a_req_l, 2'b00);
    check_eq("rst_a_ack_r", a_ack_r, 2'b00);
    check_eq("rst_a_occ", a_occ, 3'd0);
    check_eq("rst_a_dout", a_dout, 64'd0);
    #6 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_a_req_l", a_req_l, 2'b11);
    check_eq("rel_s_req_l", s_req_l, 3'b111);
    check_eq("rel_x_req_l", x_req_l, 1'b1);

    // 5 + 7 with minimum latency
    a_req_r = 2'b11;
    grant_a(32'd5, 32'd7);
    check_eq("lat_req_l_drop", a_req_l, 2'b00);
    @(posedge clk); #1;
    check_eq("lat_fire_occ", a_occ, 3'd1);
    check_eq("lat_fire_ack_r", a_ack_r, 2'b00);
    check_eq("lat_fire_req_l", a_req_l, 2'b11);
    @(posedge clk); #1;
    check_eq("lat_ack_r", a_ack_r, 2'b11);
    check_eq("lat_dout0", a_dout[31:0], 32'd12);
    check_eq("lat_dout1", a_dout[63:32], 32'd12);
    check_eq("lat_occ_after_read", a_occ, 3'd0);
    @(posedge clk); #1;
    check_eq("ack_r_one_cycle", a_ack_r, 2'b00);
    check_eq("dout0_hold", a_dout[31:0], 32'd12);
    a_got0.delete();
    a_got1.delete();

    // Consumer 1 stalls: fill the buffer, then offer one more operand set
    a_req_r = 2'b01;
    for (int k = 0; k < 5; k++) begin
      wait_ready_a();
      grant_a(32'(k + 1), 32'd100);
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("full_occ", a_occ, 3'd4);
    check_eq("full_req_l", a_req_l, 2'b00);
    check_eq("full_c0_count", a_got0.size(), 4);
    check_eq("full_c1_count", a_got1.size(), 0);
    for (int k = 0; k < 4; k++) check_eq("full_c0_order", a_got0[k], 32'(101 + k));

    // Consumer 1 frees one slot; the held operands fire one edge later
    a_req_r = 2'b11;
    @(posedge clk); #1;
    check_eq("free_occ", a_occ, 3'd3);
    check_eq("free_ack_r", a_ack_r, 2'b10);
    check_eq("free_dout1", a_dout[63:32], 32'd101);
    check_eq("free_req_l_held", a_req_l, 2'b00);
    a_req_r = 2'b01;
    @(posedge clk); #1;
    check_eq("refire_occ", a_occ, 3'd4);
    check_eq("refire_req_l", a_req_l, 2'b11);
    @(posedge clk); #1;
    check_eq("refire_ack_r", a_ack_r, 2'b01);
    check_eq("refire_dout0", a_dout[31:0], 32'd105);

    // Drain, buffer two results, then reset between edges
    a_req_r = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    check_eq("drain_occ", a_occ, 3'd0);
    a_req_r = 2'b00;
    wait_ready_a();
    grant_a(32'd1, 32'd1);
    wait_ready_a();
    grant_a(32'd2, 32'd2);
    @(posedge clk); #1;
    check_eq("two_buffered_occ", a_occ, 3'd2);
    a_req_r = 2'b01;
    @(posedge clk); #1;
    check_eq("pre_rst_ack_r", a_ack_r, 2'b01);
    check_eq("pre_rst_dout0", a_dout[31:0], 32'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_ack_r", a_ack_r, 2'b00);
    check_eq("async_rst_occ", a_occ, 3'd0);
    check_eq("async_rst_req_l", a_req_l, 2'b00);
    check_eq("async_rst_dout", a_dout, 64'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("rel_before_edge_req_l", a_req_l, 2'b00);
    @(posedge clk); #1;
    check_eq("rel_edge_req_l", a_req_l, 2'b11);
    a_got0.delete();
    a_got1.delete();
    a_req_r = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    check_eq("discard_c0", a_got0.size(), 0);
    check_eq("discard_c1", a_got1.size(), 0);
    check_eq("discard_occ", a_occ, 3'd0);
    a_req_r = 2'b00;

    // sub: 10 - 3 - 2 = 5
    s_req_r = 1'b1;
    s_ack_l = 3'b111;
    s_din   = {32'd2, 32'd3, 32'd10};
    @(posedge clk); #1;
    s_ack_l = 3'b000;
    check_eq("sub_req_l_drop", s_req_l, 3'b000);
    @(posedge clk); #1;
    check_eq("sub_fire_ack_r", s_ack_r, 1'b0);
    @(posedge clk); #1;
    check_eq("sub_ack_r", s_ack_r, 1'b1);
    check_eq("sub_dout", s_dout, 32'd5);

    // sub, staggered grants; re-grant of a held operand is ignored: 3 - 5 - 1
    s_ack_l = 3'b001;
    s_din   = {32'd0, 32'd0, 32'd3};
    @(posedge clk); #1;
    check_eq("sub_stag_req_l0", s_req_l, 3'b110);
    s_ack_l = 3'b011;
    s_din   = {32'd0, 32'd5, 32'd99};
    @(posedge clk); #1;
    check_eq("sub_stag_req_l1", s_req_l, 3'b100);
    s_ack_l = 3'b100;
    s_din   = {32'd1, 32'd77, 32'd88};
    @(posedge clk); #1;
    s_ack_l = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("sub_stag_ack_r", s_ack_r, 1'b1);
    check_eq("sub_stag_dout", s_dout, 32'hFFFF_FFFD);
    s_req_r = 1'b0;

    // mul 8-bit with wraparound
    m_req_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("mul_req_l_ready", m_req_l, 2'b11);
      m_ack_l = 2'b11;
      m_din   = {m_b[k], m_a[k]};
      @(posedge clk); #1;
      m_ack_l = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("mul_ack_r", m_ack_r, 1'b1);
      check_eq("mul_dout", m_dout, m_e[k]);
    end
    m_req_r = 1'b0;

    // addi stream with random producer gaps and consumer stalls
    x_sent = 0;
    x_idx0 = 0;
    x_idx1 = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (x_idx0 >= 1000 && x_idx1 >= 1000) break;
      @(posedge clk); #1;
      x_ack_l = 1'b0;
      if (x_ack_r[0]) begin
        if (x_idx0 < 1000) check_eq("addi_c0", x_dout[31:0], x_exp[x_idx0]);
        else check_eq("addi_c0_extra", x_idx0, 999);
        x_idx0++;
      end
      if (x_ack_r[1]) begin
        if (x_idx1 < 1000) check_eq("addi_c1", x_dout[63:32], x_exp[x_idx1]);
        else check_eq("addi_c1_extra", x_idx1, 999);
        x_idx1++;
      end
      if (x_sent < 1000 && x_req_l[0] && $urandom_range(0, 3) != 0) begin
        x_din          = $urandom;
        x_exp[x_sent]  = x_din + 32'd2;
        x_ack_l        = 1'b1;
        x_sent++;
      end
      x_req_r = 2'($urandom_range(0, 3));
    end
    check_eq("addi_sent", x_sent, 1000);
    check_eq("addi_c0_count", x_idx0, 1000);
    check_eq("addi_c1_count", x_idx1, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_async_operator.md
FIFO_ASYNC_OPERATOR -- requirements
Module: fifo_async_operator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter OP, default "add": one of reg, in, out, add, sub, mul, addi, subi, muli, and, or, xor.
REQ-003 Parameter IMMEDIATE, default 0: constant operand for addi/subi/muli.
REQ-004 Parameter INPUT_SIZE, default 2: operand channel count, legal range 1..4.
REQ-005 Parameter OUTPUT_SIZE, default 2: independent consumer channel count, legal range 1..4.
REQ-006 Parameter DEPTH, default 4: result buffer entries, power of two, minimum 2.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 req_l  output  INPUT_SIZE  per-operand pull request to the upstream producer.
REQ-010 ack_l  input  INPUT_SIZE  per-operand one-cycle grant; the din slice is valid in the same cycle.
REQ-011 din  input  DATA_WIDTH*INPUT_SIZE  operands; slice i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-012 req_r  input  OUTPUT_SIZE  per-consumer pull request.
REQ-013 ack_r  output  OUTPUT_SIZE  per-consumer one-cycle grant.
REQ-014 dout  output  DATA_WIDTH*OUTPUT_SIZE  per-consumer result slice; valid while the matching ack_r bit is 1.
REQ-015 occupancy  output  clog2(DEPTH)+1  number of buffer entries not yet consumed by every consumer.

Function
REQ-016 Each operand channel i keeps a has[i] flag; req_l[i] is 1 whenever has[i]=0 and no ack_l[i] is being sampled this cycle.
REQ-017 ack_l[i] sampled 1 shall register din slice i, set has[i], and drive req_l[i] to 0 at the same edge; ack_l[i] while has[i]=1 is ignored.
REQ-018 Fire condition: all has bits are 1 and occupancy<DEPTH; at that edge the result is written to the entry at wr_ptr, wr_ptr increments, and all has bits clear.
REQ-019 When the buffer is full, has bits hold and req_l stays 0 until a slot is freed; no operand is lost or overwritten.
REQ-020 Result is the left fold over operands 0..INPUT_SIZE-1 (sub: op0-op1-...-opN-1), truncated modulo 2^DATA_WIDTH.
REQ-021 reg/in/out pass operand 0; addi/subi/muli apply IMMEDIATE to operand 0; the immediate ops, reg, in and out require INPUT_SIZE=1.
REQ-022 Each consumer j has its own rd_ptr[j]; consumer j has data available when rd_ptr[j]!=wr_ptr, compared with a wrap bit.
REQ-023 With req_r[j]=1, ack_r[j]=0 and data available, the edge shall set ack_r[j]=1, load dout slice j from the entry at rd_ptr[j], and increment rd_ptr[j].
REQ-024 ack_r[j] shall return to 0 on the following edge, so it is never high in two consecutive cycles.
REQ-025 Consumers are independent: a stalled consumer does not block the others until the buffer fills.
REQ-026 occupancy = wr_ptr minus the slowest rd_ptr; an entry is freed only after every consumer has taken it.
REQ-027 A fire and a freeing read on the same edge: occupancy is unchanged; a full buffer does not fire on the edge that frees its slot, only on the next edge.
REQ-028 Minimum latency: the last ack_l sampled at edge t gives a fire at edge t+1 and ack_r at edge t+2, with the buffer empty and req_r held at 1.
REQ-029 Pointers wrap modulo DEPTH, with a wrap bit distinguishing full from empty.
REQ-030 dout slice j holds its last value when ack_r[j]=0.

Reset
REQ-031 rst=0 shall immediately clear has, req_l, ack_r, dout, all pointers and occupancy, regardless of clk.
REQ-032 A reset asserted mid-transfer discards captured operands and buffered results.
REQ-033 req_l goes to all ones on the first rising edge after rst returns to 1.
REQ-034 Buffer memory contents need no reset.

Verification
REQ-035 Config add, INPUT_SIZE=2, OUTPUT_SIZE=1: ack_l grants with 5 and 7 at edge t, req_r held 1 -> ack_r=1 with dout=12 at edge t+2.
REQ-036 Config sub, INPUT_SIZE=3: operands 10, 3, 2 -> result 5; config mul, DATA_WIDTH=8: 16*16 -> 0 (wrap).
REQ-037 Config OUTPUT_SIZE=2, DEPTH=4: consumer 1 holds req_r=0 while 4 results are produced -> occupancy=4 and req_l all 0; consumer 0 still receives all 4 in order.
REQ-038 In the full state of REQ-037, consumer 1 then takes one result -> occupancy=3 on that edge, fire on the next edge, no operand lost.
REQ-039 Config addi, IMMEDIATE=2, INPUT_SIZE=1: 1000 random values with random req_r/ack_l gaps -> each consumer sees input+2 in order, with no duplicates and no drops.
REQ-040 rst=0 pulsed between clk edges with 2 entries buffered -> ack_r, occupancy and req_l go to 0 immediately, and req_l goes all ones on the first edge after release.
